// File: rtl/a1csa_serial_adder_if.sv
// ============================================================================
// a1csa_serial_adder_if : operand/result handshake bundle for the serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

interface a1csa_serial_adder_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/a1csa_serial_adder.sv
// ============================================================================
// a1csa_serial_adder : nibble-serial W-bit adder built on one 4-bit a1csa slice
// Rev 1.0
// ============================================================================
`default_nettype none

module a1csa_serial_adder #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  a1csa_serial_adder_if.slave   bus
);

  localparam int NIB = W / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [4:0]      raw_sum;
  logic            gen;
  logic            prop;
  logic [3:0]      slice_s;

  // 4-bit a1csa slice: the +1 variant is selected by the running carry
  always_comb begin
    raw_sum = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]};
    gen     = raw_sum[4];
    prop    = &raw_sum[3:0];
    slice_s = carry_q ? (raw_sum[3:0] + 4'd1) : raw_sum[3:0];
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = {4'b0000, a_sh_q[W-1:4]};
        b_sh_d   = {4'b0000, b_sh_q[W-1:4]};
        sum_sh_d = {slice_s, sum_sh_q[W-1:4]};
        carry_d  = gen | (prop & carry_q);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // All outputs decode straight from registers; no input-to-output path
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = carry_q;

endmodule

`default_nettype wire
